// File: rtl/window_addr_gen.sv
// window_addr_gen: raster-scans an IMG_W x IMG_H image and streams the nine 3x3 window
// tap addresses per pixel over valid/ready, with clamp or zero-flag border handling.
module window_addr_gen #(
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 120,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int ADDR_W      = 17,
    parameter int BORDER_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] address,
    output logic [X_W-1:0]    pix_x,
    output logic [Y_W-1:0]    pix_y,
    output logic [3:0]        sel,
    output logic              tap_oob,
    output logic              last_tap,
    output logic              last_pix
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);
    localparam logic [X_W:0]   X_MAX  = (X_W + 1)'(IMG_W - 1);
    localparam logic [Y_W:0]   Y_MAX  = (Y_W + 1)'(IMG_H - 1);

    state_t            state;
    logic              adv, load, idle, wrap, xwrap;
    logic [3:0]        ns, col;
    logic [1:0]        row;
    logic [X_W-1:0]    nx, ax;
    logic [Y_W-1:0]    ny, ay;
    logic [X_W:0]      tx;
    logic [Y_W:0]      ty;
    logic              x_lo, x_hi, y_lo, y_hi, n_oob, n_last_pix;
    logic [ADDR_W-1:0] n_addr;

    // Next beat's coordinates are computed ahead so every output can be registered.
    always_comb begin
        idle       = state == S_IDLE;
        adv        = addr_valid && addr_ready;
        load       = (idle && start) || adv;
        wrap       = sel == 4'd8;
        xwrap      = pix_x == X_LAST;
        ns         = (idle || wrap) ? 4'd0 : sel + 4'd1;
        nx         = (idle || (wrap && xwrap)) ? '0 : wrap ? pix_x + X_W'(1) : pix_x;
        ny         = idle ? '0 : (wrap && xwrap) ? pix_y + Y_W'(1) : pix_y;
        row        = (ns < 4'd3) ? 2'd0 : (ns < 4'd6) ? 2'd1 : 2'd2;
        col        = ns - ((row == 2'd0) ? 4'd0 : (row == 2'd1) ? 4'd3 : 4'd6);
        tx         = {1'b0, nx} + (X_W + 1)'(col) - (X_W + 1)'(1);
        ty         = {1'b0, ny} + (Y_W + 1)'(row) - (Y_W + 1)'(1);
        x_lo       = tx[X_W];
        x_hi       = !tx[X_W] && tx > X_MAX;
        y_lo       = ty[Y_W];
        y_hi       = !ty[Y_W] && ty > Y_MAX;
        n_oob      = BORDER_MODE != 0 && (x_lo || x_hi || y_lo || y_hi);
        ax         = n_oob ? nx : x_lo ? '0 : x_hi ? X_LAST : tx[X_W-1:0];
        ay         = n_oob ? ny : y_lo ? '0 : y_hi ? Y_LAST : ty[Y_W-1:0];
        n_addr     = ADDR_W'(ay) * ADDR_W'(IMG_W) + ADDR_W'(ax);
        n_last_pix = nx == X_LAST && ny == Y_LAST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr_valid <= 1'b0;
            address    <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            sel        <= '0;
            tap_oob    <= 1'b0;
            last_tap   <= 1'b0;
            last_pix   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                pix_x    <= nx;
                pix_y    <= ny;
                sel      <= ns;
                address  <= n_addr;
                tap_oob  <= n_oob;
                last_tap <= ns == 4'd8;
                last_pix <= n_last_pix;
            end
            case (state)
                S_IDLE: if (start) begin
                    state      <= S_RUN;
                    busy       <= 1'b1;
                    addr_valid <= 1'b1;
                end
                S_RUN: if (adv && last_tap && last_pix) begin
                    state      <= S_FIN;
                    busy       <= 1'b0;
                    addr_valid <= 1'b0;
                    done       <= 1'b1;
                    address    <= '0;
                    pix_x      <= '0;
                    pix_y      <= '0;
                    sel        <= '0;
                    tap_oob    <= 1'b0;
                    last_tap   <= 1'b0;
                    last_pix   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/window_addr_gen.md
# window_addr_gen

Sequential 3x3 neighbourhood address generator for the display/filter path. It raster-scans a parametrised image and emits, per pixel, the nine frame-buffer read addresses of the window in tap order 0..8 (row-major, tap 4 = centre) over a valid/ready stream. It supersedes the fixed 160x120 combinational tap mux with configurable geometry and explicit border handling (clamp or zero-flag). It sits between the frame controller (start/done) and the frame-buffer read port feeding the median/edge kernels.

## Interface

Parameters:

- `IMG_W`, 160: image width in pixels, ≥2
- `IMG_H`, 120: image height in pixels, ≥2
- `X_W`, 8: x coordinate width, ≥ clog2(IMG_W)
- `Y_W`, 7: y coordinate width, ≥ clog2(IMG_H)
- `ADDR_W`, 17: address width, ≥ clog2(IMG_W*IMG_H)
- `BORDER_MODE`, 0: 0 = clamp (replicate edge pixel), 1 = zero (flag out-of-image taps)

Ports (one clock; reset is asynchronous and active-low):

- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `start` in 1: one-cycle pulse that begins a frame scan, ignored while busy
- `busy` out 1: high from the cycle after an accepted start until done
- `done` out 1: one-cycle pulse after the final tap is accepted
- `addr_valid` out 1: tap beat valid
- `addr_ready` in 1: downstream accepts the beat
- `address` out ADDR_W: read address of the current tap
- `pix_x` out X_W: centre x of the current window
- `pix_y` out Y_W: centre y of the current window
- `sel` out 4: tap index, 0..8
- `tap_oob` out 1: tap lies outside the image (zero mode only; always 0 in clamp mode)
- `last_tap` out 1: sel == 8
- `last_pix` out 1: pix_x == IMG_W-1 and pix_y == IMG_H-1

## Operation

- States:
  - IDLE: start → RUN.
  - RUN: the handshake advances the tap. When the beat with last_tap && last_pix is accepted → DONE.
  - DONE: lasts one cycle, done = 1, then → IDLE.
- Tap offsets: dy = sel/3 − 1 and dx = sel%3 − 1, giving sel0 = (−1,−1) through sel8 = (+1,+1).
- Tap coordinate: tx = pix_x + dx, ty = pix_y + dy, computed signed one bit wider than X_W/Y_W.
- Clamp mode:
  - tx is clamped to [0, IMG_W−1] and ty to [0, IMG_H−1].
  - address = ty*IMG_W + tx.
  - tap_oob = 0.
- Zero mode:
  - If tx or ty is out of range, tap_oob = 1 and address = centre address (pix_y*IMG_W + pix_x).
  - Otherwise tap_oob = 0 and address = ty*IMG_W + tx.
- Multiplication is by a constant only. A running row base (incremented by IMG_W per row) is permitted. No general multiplier.
- Advance on addr_valid && addr_ready:
  - sel increments.
  - After sel 8, sel returns to 0 and pix_x increments.
  - After pix_x reaches IMG_W−1, pix_x returns to 0 and pix_y increments.
- Scan order is raster: x fastest, then y.
- start during RUN or DONE is ignored. start arriving in the same cycle as done is ignored.
- Reset (at any time, including mid-scan) immediately forces IDLE and all outputs to 0. The next scan restarts from pixel (0,0), sel 0.

## Timing

- All outputs are driven from flops. No combinational path from addr_ready or start to any output.
- Reset values: busy 0, done 0, addr_valid 0, address 0, pix_x 0, pix_y 0, sel 0, tap_oob 0, last_tap 0, last_pix 0.
- Start to first beat: start sampled at edge N, then busy = 1 and addr_valid = 1 with pixel (0,0), sel 0 from edge N+1.
- Handshake:
  - While addr_valid && !addr_ready, every output is held stable.
  - addr_valid does not drop until the final beat is accepted.
- Throughput: with addr_ready held high, one tap per cycle, so a frame takes 9*IMG_W*IMG_H cycles.
- End of frame: final beat accepted at edge M, then at edge M+1 addr_valid = 0, busy = 0, done = 1 for exactly one cycle.
- Address arithmetic is exact within ADDR_W. No wrap occurs for valid parameters; the bench asserts address < IMG_W*IMG_H.

## Test plan

1. Default parameters, clamp mode, ready high, pixel (0,0): sel0..8 → addresses 0, 0, 1, 0, 0, 1, 160, 160, 161; tap_oob = 0 throughout.
2. Zero mode, pixel (0,0): sel0, 1, 2, 3, 6 → tap_oob = 1 with address 0; sel4, 5, 7, 8 → addresses 0, 1, 160, 161 with tap_oob = 0.
3. Interior pixel (5,3): sel0 → 324, sel4 → 485, sel8 → 646. Pixel (159,119) in clamp mode: sel8 → 19199 with last_pix = 1 and last_tap = 1.
4. IMG_W = 4, IMG_H = 3, ready high: exactly 108 beats; done pulses exactly once, one cycle after the 108th beat; busy is high for exactly 108 cycles; a start pulsed mid-scan changes nothing.
5. Random addr_ready (about 50% duty): beat sequence identical to the ready-high run; all outputs stable across every stalled cycle.
6. rst_n asserted during beat 40 of a 4x3 scan: all outputs go to 0 immediately; a new start yields pixel (0,0), sel 0 with address 0 on the next cycle.
